// File: rtl/demux1x4_reg.sv
// rtl/demux1x4_reg.sv - registered 1-to-4 byte demultiplexer with per-channel valid/ack
module demux1x4_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       SEL,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic [WIDTH-1:0] OUT0,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  output logic [WIDTH-1:0] OUT3,
  output logic [3:0]       VALID,
  input  logic [3:0]       ACK,
  output logic [2:0]       OCUPADOS
);

  logic [WIDTH-1:0] out_q [4];
  logic [WIDTH-1:0] out_d [4];
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic             wr_en;

  // A full channel may still accept when its consumer drains it in the same edge.
  assign D_READY = ~valid_q[SEL] | ACK[SEL];
  assign wr_en   = D_VALID & D_READY;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_d[k]   = out_q[k];
      valid_d[k] = valid_q[k] & ~ACK[k];
      if (wr_en && (SEL == 2'(k))) begin
        out_d[k]   = D;
        valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        out_q[k] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        out_q[k] <= out_d[k];
      end
      valid_q <= valid_d;
    end
  end

  assign OUT0     = out_q[0];
  assign OUT1     = out_q[1];
  assign OUT2     = out_q[2];
  assign OUT3     = out_q[3];
  assign VALID    = valid_q;
  assign OCUPADOS = 3'(valid_q[0]) + 3'(valid_q[1]) + 3'(valid_q[2]) + 3'(valid_q[3]);

endmodule

// File: doc/demux1x4_reg.md
# demux1x4_reg

Registered 1-to-4 demultiplexer with a per-channel valid/ack handshake. It performs the inverse of the 4-to-1 byte selector used in the memory-game datapath. A single producer writes a byte tagged with a 2-bit destination. The block holds the byte in that destination's one-entry output register until the consumer acknowledges it. It sits between the game FSM's data path and four independent consumers, for example display, LED bank, sound and score logic.

## Interface
- WIDTH, 8, data width of the input and of each output register
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- D  in  WIDTH  input data
- SEL  in  2  destination channel for D (0..3)
- D_VALID  in  1  producer offers D for channel SEL this cycle
- D_READY  out  1  combinational; channel SEL can accept this cycle
- OUT0, OUT1, OUT2, OUT3  out  WIDTH each  channel output registers
- VALID  out  4  VALID[k]=1: OUTk holds unacknowledged data
- ACK  in  4  ACK[k]=1: consumer k takes OUTk this cycle
- OCUPADOS  out  3  combinational count of set VALID bits (0..4)

## Operation
- Reset:
  - OUT0..OUT3 = 0, VALID = 4'b0000, OCUPADOS = 0.
  - D_READY = 1, because no channel is full.
- D_READY = ~VALID[SEL] | ACK[SEL]. A channel accepts a new byte if it is empty, or if it is full and being acknowledged in the same cycle.
- Write: on a rising edge with D_VALID & D_READY, OUT[SEL] <= D and VALID[SEL] <= 1. Only channel SEL is affected.
- Acknowledge: on a rising edge with VALID[k] & ACK[k] and no write to k, VALID[k] <= 0.
  - OUTk keeps its last value; it is not cleared.
- Simultaneous write and ack to the same channel k: VALID[k] stays 1 and OUTk takes the new D. This gives back-to-back throughput of one byte per cycle per channel.
- Simultaneous write to channel j and ack of channel k, with j != k: both take effect independently in the same edge.
- Any subset of ACK bits may be active in one cycle. Each one is handled independently.
- ACK[k] while VALID[k]=0 is ignored and does not change state.
- D_VALID while D_READY=0: no state change. The producer must hold D and SEL until D_READY=1. The block never drops or overwrites unacknowledged data.
- D_VALID=0: D and SEL are don't-care. D_READY still reflects the current SEL.
- SEL is 2 bits, so every value is a legal channel. There is no default or invalid case.
- OCUPADOS = VALID[0]+VALID[1]+VALID[2]+VALID[3], computed as a 3-bit unsigned sum.

## Timing
- Write latency: 1 cycle. A byte accepted at edge n is visible on OUT[SEL] with VALID[SEL]=1 right after edge n.
- Ack latency: 1 cycle. VALID[k] falls right after the accepting edge.
- D_READY and OCUPADOS are combinational. D_READY has a path from SEL and ACK; the producer must sample it before the edge.
- Reset asserted mid-operation clears all outputs asynchronously, without waiting for a clock edge. Pending data is discarded. The first write can be accepted at the first rising edge after reset deasserts.
- No combinational path exists from D to any OUTk. All outputs except D_READY and OCUPADOS are registered.

## Test plan
- **Reset:** assert reset mid-stream after loading all channels -> OUT0..3=0, VALID=0000, OCUPADOS=0, D_READY=1, all without a clock edge.
- **Fill and block:**
  - Write 8'hA5 to SEL=2 -> OUT2=A5, VALID=0100, OCUPADOS=1.
  - Write 8'h3C to SEL=2 without ACK -> D_READY=0 and OUT2 stays A5.
- **Ack:**
  - ACK=0100 with VALID[2]=1 -> VALID=0000 next cycle and OUT2 still A5.
  - ACK=1011 while those channels are empty -> no change.
- **Back-to-back on one channel:**
  - Pulse D_VALID on SEL=1 with bytes 01, 02, 03 while ACK[1]=1 every cycle -> D_READY=1 throughout, OUT1 follows 01, 02, 03 on consecutive cycles, VALID[1] stays 1.
  - Drop ACK after the last byte -> VALID[1]=1 holding 03.
- **Parallel:** in the same cycle, write 8'hFF to SEL=0 while ACK=1000 with VALID[3]=1 -> VALID[0]=1, VALID[3]=0, OUT0=FF.
- **Full occupancy:** load all four channels with 11, 22, 33, 44 -> OCUPADOS=4 and D_READY=0 for every SEL. Then ACK=1111 -> OCUPADOS=0.
